// File: rtl/motor_pkg.sv
// motor_pkg: shared types and helpers for the motor drive controller.
//   dir_state_t : direction FSM encoding (also exported on the display port)
//   HB_*        : H-bridge input pair codes, bit0 = IN_A, bit1 = IN_B
//   decode_req  : switch pair -> requested direction (both set means IDLE)
//   hb_pair     : FSM state -> H-bridge pair (coast outside FWD/REV)
package motor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      REV  = 2'd2,
      DEAD = 2'd3
   } dir_state_t;

   localparam logic [1:0] HB_OFF = 2'b00;
   localparam logic [1:0] HB_FWD = 2'b01;
   localparam logic [1:0] HB_REV = 2'b10;

   function automatic dir_state_t decode_req(input logic fwd, input logic rev);
      dir_state_t r;
      if (fwd && !rev) begin
         r = FWD;
      end else if (rev && !fwd) begin
         r = REV;
      end else begin
         r = IDLE;
      end
      return r;
   endfunction

   function automatic logic [1:0] hb_pair(input dir_state_t s);
      logic [1:0] r;
      case (s)
         FWD:     r = HB_FWD;
         REV:     r = HB_REV;
         default: r = HB_OFF;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/motor_drive_ctrl_oc_guard.sv
// oc_guard: per-channel over-current lockout.
//   clk, rst_n      : clock, asynchronous active-low reset
//   oc_i            : raw comparator output (asynchronous), 1 = over current
//   active_i        : FSM is driving the bridge (FWD or REV)
//   period_start_i  : PWM period counter is at 0
//   clear_i         : drop all lockout state immediately (primary enable low)
//   fault_o         : registered lockout flag
//   blocked_o       : channel must not be enabled this cycle
module oc_guard
   import motor_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int OC_HOLD     = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic oc_i,
   input  logic active_i,
   input  logic period_start_i,
   input  logic clear_i,
   output logic fault_o,
   output logic blocked_o
);

   localparam int            TW     = $clog2(OC_HOLD + 1);
   localparam logic [TW-1:0] HOLD_C = TW'(OC_HOLD);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   fault_q, fault_d;
   logic                   lock_q, lock_d;
   logic [TW-1:0]          tmr_q, tmr_d;
   logic                   oc_s;
   logic                   trip_s;

   // Synchroniser chain plus lockout state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         fault_q <= 1'b0;
         lock_q  <= 1'b0;
         tmr_q   <= '0;
      end else begin
         sync_q[0] <= oc_i;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
         fault_q <= fault_d;
         lock_q  <= lock_d;
         tmr_q   <= tmr_d;
      end
   end

   // Trip / hold-timer / re-arm logic. lock_q outlives fault_q so the channel
   // only comes back on a period boundary and never mid-period.
   always_comb begin
      oc_s    = sync_q[SYNC_STAGES-1];
      trip_s  = active_i & oc_s & ~fault_q & ~clear_i;
      fault_d = fault_q;
      lock_d  = lock_q;
      tmr_d   = tmr_q;
      if (clear_i) begin
         fault_d = 1'b0;
         lock_d  = 1'b0;
         tmr_d   = '0;
      end else if (trip_s) begin
         fault_d = 1'b1;
         lock_d  = 1'b1;
         tmr_d   = HOLD_C;
      end else if (fault_q) begin
         if (oc_s) begin
            tmr_d = HOLD_C;
         end else begin
            tmr_d   = tmr_q - TW'(1);
            fault_d = (tmr_q != TW'(1));
         end
      end else if (period_start_i) begin
         lock_d = 1'b0;
      end else begin
         lock_d = lock_q;
      end
      blocked_o = trip_s | fault_q | (lock_q & ~period_start_i);
   end

   assign fault_o = fault_q;

endmodule

// File: rtl/motor_drive_ctrl.sv
// motor_drive_ctrl: PWM generation, direction FSM with dead time and per-channel
// over-current lockout for an N_CH H-bridge motor drive.
//   clk, rst_n        : clock, asynchronous active-low reset
//   enable            : primary enable switch
//   dir_fwd, dir_rev  : direction request switches
//   duty_code         : duty in steps of 1/DUTY_STEPS (values above saturate)
//   oc[N_CH]          : comparator outputs, 1 = over current
//   pwm_en[N_CH]      : H-bridge enable per channel (registered)
//   hb_in[2*N_CH]     : IN_A/IN_B per channel, bit 2i = IN_A (registered)
//   fault[N_CH]       : channel locked out
//   dir_state         : FSM state for the display (0 IDLE, 1 FWD, 2 REV, 3 DEAD)
module motor_drive_ctrl
   import motor_pkg::*;
#(
   parameter int N_CH        = 2,
   parameter int CNT_W       = 10,
   parameter int PERIOD      = 1000,
   parameter int DUTY_W      = 3,
   parameter int DUTY_STEPS  = 4,
   parameter int DEAD_CYC    = 50,
   parameter int OC_HOLD     = 1000,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                dir_fwd,
   input  logic                dir_rev,
   input  logic [DUTY_W-1:0]   duty_code,
   input  logic [N_CH-1:0]     oc,
   output logic [N_CH-1:0]     pwm_en,
   output logic [2*N_CH-1:0]   hb_in,
   output logic [N_CH-1:0]     fault,
   output logic [1:0]          dir_state
);

   localparam int                SW        = DUTY_W + 3;
   localparam int                PW        = CNT_W + DUTY_W;
   localparam int                CW        = CNT_W + 1;
   localparam int                DW        = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
   localparam logic [DUTY_W-1:0] STEPS_C   = DUTY_W'(DUTY_STEPS);
   localparam logic [DW-1:0]     DEAD_LOAD = DW'(DEAD_CYC - 1);

   logic [SW-1:0]       sync_q [SYNC_STAGES];
   logic                en_s, fwd_s, rev_s;
   logic [DUTY_W-1:0]   duty_s, duty_clip_s;
   logic [PW-1:0]       prod_s;
   logic [CW-1:0]       cmp_q, cmp_eff_s;
   logic [CNT_W-1:0]    cnt_q;
   logic                period_start_s, pwm_raw_s, active_s;
   dir_state_t          state_q, state_d, req_s;
   logic [DW-1:0]       dead_q, dead_d;
   logic [N_CH-1:0]     fault_s, blocked_s;
   logic [N_CH-1:0]     pwm_en_q, pwm_en_d;
   logic [2*N_CH-1:0]   hb_q, hb_d;

   // Switch synchronisers and period counter / duty latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
         cnt_q <= '0;
         cmp_q <= '0;
      end else begin
         sync_q[0] <= {enable, dir_fwd, dir_rev, duty_code};
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
         cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
         cmp_q <= cmp_eff_s;
      end
   end

   // The new compare value is used during the count==0 cycle itself, so a
   // period is always produced entirely from one duty value.
   always_comb begin
      {en_s, fwd_s, rev_s, duty_s} = sync_q[SYNC_STAGES-1];
      period_start_s = (cnt_q == '0);
      duty_clip_s    = (duty_s > STEPS_C) ? STEPS_C : duty_s;
      prod_s         = PW'(duty_clip_s) * PW'(PERIOD);
      if (period_start_s) begin
         cmp_eff_s = CW'(prod_s / PW'(DUTY_STEPS));
      end else begin
         cmp_eff_s = cmp_q;
      end
      pwm_raw_s = ({1'b0, cnt_q} < cmp_eff_s);
   end

   // Direction FSM and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         dead_q   <= '0;
         pwm_en_q <= '0;
         hb_q     <= '0;
      end else begin
         state_q  <= state_d;
         dead_q   <= dead_d;
         pwm_en_q <= pwm_en_d;
         hb_q     <= hb_d;
      end
   end

   // Next-state and pin values; IDLE is always visited for one cycle after DEAD.
   always_comb begin
      state_d  = state_q;
      dead_d   = dead_q;
      req_s    = decode_req(fwd_s, rev_s);
      active_s = (state_q == FWD) || (state_q == REV);
      case (state_q)
         IDLE: begin
            if (en_s && (req_s != IDLE)) begin
               state_d = req_s;
            end else begin
               state_d = IDLE;
            end
         end
         FWD, REV: begin
            if (!en_s || (req_s != state_q)) begin
               state_d = DEAD;
               dead_d  = DEAD_LOAD;
            end else begin
               state_d = state_q;
            end
         end
         DEAD: begin
            if (dead_q == '0) begin
               state_d = IDLE;
            end else begin
               dead_d = dead_q - DW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      if (active_s && pwm_raw_s) begin
         pwm_en_d = ~blocked_s;
      end else begin
         pwm_en_d = '0;
      end
      hb_d = {N_CH{hb_pair(state_q)}};
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_guard
      oc_guard #(
         .SYNC_STAGES (SYNC_STAGES),
         .OC_HOLD     (OC_HOLD)
      ) u_guard (
         .clk            (clk),
         .rst_n          (rst_n),
         .oc_i           (oc[i]),
         .active_i       (active_s),
         .period_start_i (period_start_s),
         .clear_i        (~en_s),
         .fault_o        (fault_s[i]),
         .blocked_o      (blocked_s[i])
      );
   end

   assign pwm_en    = pwm_en_q;
   assign hb_in     = hb_q;
   assign fault     = fault_s;
   assign dir_state = state_q;

endmodule

// File: tb/tb_motor_drive_ctrl.sv
module tb_motor_drive_ctrl;

   localparam int N_CH = 2, CNT_W = 10, PERIOD = 20, DUTY_W = 3, DUTY_STEPS = 4;
   localparam int DEAD_CYC = 4, OC_HOLD = 10, SYNC_STAGES = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              enable = 1'b0, dir_fwd = 1'b0, dir_rev = 1'b0;
   logic [DUTY_W-1:0] duty_code = '0;
   logic [N_CH-1:0]   oc = '0;
   logic [N_CH-1:0]   pwm_en, fault;
   logic [2*N_CH-1:0] hb_in;
   logic [1:0]        dir_state;

   int n_cmp = 0;
   int n_fail = 0;

   motor_drive_ctrl #(
      .N_CH(N_CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .DUTY_W(DUTY_W),
      .DUTY_STEPS(DUTY_STEPS), .DEAD_CYC(DEAD_CYC), .OC_HOLD(OC_HOLD),
      .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .dir_fwd(dir_fwd),
      .dir_rev(dir_rev), .duty_code(duty_code), .oc(oc), .pwm_en(pwm_en),
      .hb_in(hb_in), .fault(fault), .dir_state(dir_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Inputs as seen after the synchroniser: the value sampled SYNC_STAGES edges ago.
   bit  h_en [SYNC_STAGES];
   bit  h_fwd[SYNC_STAGES];
   bit  h_rev[SYNC_STAGES];
   int  h_duty[SYNC_STAGES];
   bit  h_oc [N_CH][SYNC_STAGES];
   int  m_cnt, m_high, m_dir, m_dead_left;
   bit  m_fault[N_CH], m_wait_period[N_CH];
   int  m_hold[N_CH];
   logic [N_CH-1:0]   e_pwm, e_fault;
   logic [2*N_CH-1:0] e_hb;
   int  e_dir;

   task automatic model_reset();
      for (int k = 0; k < SYNC_STAGES; k++) begin
         h_en[k] = 0; h_fwd[k] = 0; h_rev[k] = 0; h_duty[k] = 0;
         for (int c = 0; c < N_CH; c++) h_oc[c][k] = 0;
      end
      m_cnt = 0; m_high = 0; m_dir = 0; m_dead_left = 0;
      for (int c = 0; c < N_CH; c++) begin
         m_fault[c] = 0; m_wait_period[c] = 0; m_hold[c] = 0;
      end
      e_pwm = '0; e_fault = '0; e_hb = '0; e_dir = 0;
   endtask

   // One clock edge worth of behaviour; pins show the state before the edge.
   task automatic model_step();
      bit en, f, r, ps, driving, o, trip;
      int d, req;
      en = h_en[SYNC_STAGES-1]; f = h_fwd[SYNC_STAGES-1]; r = h_rev[SYNC_STAGES-1];
      d  = h_duty[SYNC_STAGES-1];
      ps = (m_cnt == 0);
      if (ps) m_high = ((d < DUTY_STEPS) ? d : DUTY_STEPS) * PERIOD / DUTY_STEPS;
      driving = (m_dir == 1) || (m_dir == 2);
      for (int c = 0; c < N_CH; c++) begin
         e_hb[2*c]   = (m_dir == 1);
         e_hb[2*c+1] = (m_dir == 2);
         o    = h_oc[c][SYNC_STAGES-1];
         trip = driving && o && !m_fault[c] && en;
         e_pwm[c] = driving && (m_cnt < m_high) && !trip && !m_fault[c]
                    && !(m_wait_period[c] && !ps);
         if (!en) begin
            m_fault[c] = 0; m_wait_period[c] = 0; m_hold[c] = 0;
         end else if (trip) begin
            m_fault[c] = 1; m_wait_period[c] = 1; m_hold[c] = OC_HOLD;
         end else if (m_fault[c]) begin
            if (o) m_hold[c] = OC_HOLD;
            else begin
               m_hold[c]--;
               if (m_hold[c] == 0) m_fault[c] = 0;
            end
         end else if (ps) begin
            m_wait_period[c] = 0;
         end
         e_fault[c] = m_fault[c];
      end
      req = (f && !r) ? 1 : ((r && !f) ? 2 : 0);
      if (m_dir == 0) begin
         if (en && req != 0) m_dir = req;
      end else if (m_dir == 3) begin
         m_dead_left--;
         if (m_dead_left == 0) m_dir = 0;
      end else if (!en || req != m_dir) begin
         m_dir = 3; m_dead_left = DEAD_CYC;
      end
      e_dir = m_dir;
      m_cnt = (m_cnt + 1) % PERIOD;
      for (int k = SYNC_STAGES - 1; k > 0; k--) begin
         h_en[k] = h_en[k-1]; h_fwd[k] = h_fwd[k-1]; h_rev[k] = h_rev[k-1];
         h_duty[k] = h_duty[k-1];
         for (int c = 0; c < N_CH; c++) h_oc[c][k] = h_oc[c][k-1];
      end
      h_en[0] = enable; h_fwd[0] = dir_fwd; h_rev[0] = dir_rev; h_duty[0] = int'(duty_code);
      for (int c = 0; c < N_CH; c++) h_oc[c][0] = oc[c];
   endtask

   // Model advance and comparison every cycle; inputs change only at negedge+1,
   // so at the negedge they still hold the values the DUT sampled.
   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (!rst_n) model_reset();
         else model_step();
         chk("pwm_en", 32'(pwm_en), 32'(e_pwm));
         chk("hb_in", 32'(hb_in), 32'(e_hb));
         chk("fault", 32'(fault), 32'(e_fault));
         chk("dir_state", 32'(dir_state), 32'(e_dir));
      end
   end

   // ---------------- stimulus and hand-computed checks ----------------
   task automatic nxt();
      @(negedge clk);
      #1;
   endtask

   task automatic count_pwm0(output int n);
      n = 0;
      for (int k = 0; k < PERIOD; k++) begin
         nxt();
         if (pwm_en[0]) n++;
      end
   endtask

   initial begin
      int n, k;
      logic prev_fault1;
      repeat (3) nxt();
      chk("reset_pwm", 32'(pwm_en), 32'd0);
      chk("reset_dir", 32'(dir_state), 32'd0);
      rst_n = 1'b1;

      // Forward at 50 %, then 75 % from the next period, then saturated code.
      enable = 1'b1; dir_fwd = 1'b1; duty_code = 3'd2;
      repeat (50) nxt();
      chk("fwd_state", 32'(dir_state), 32'd1);
      chk("fwd_hb", 32'(hb_in[1:0]), 32'b01);
      count_pwm0(n);
      chk("duty2_high", 32'(n), 32'd10);
      repeat (7) nxt();
      duty_code = 3'd3;
      repeat (45) nxt();
      count_pwm0(n);
      chk("duty3_high", 32'(n), 32'd15);
      duty_code = 3'd7;
      repeat (45) nxt();
      count_pwm0(n);
      chk("duty7_high", 32'(n), 32'd20);

      // Reverse request: exactly DEAD_CYC cycles of DEAD, then IDLE, then REV.
      dir_fwd = 1'b0; dir_rev = 1'b1;
      k = 0;
      while (dir_state != 2'd3 && k < 10) begin nxt(); k++; end
      chk("dead_reached", 32'(dir_state), 32'd3);
      n = 0;
      while (dir_state == 2'd3 && n < 20) begin nxt(); n++; end
      chk("dead_len", 32'(n), 32'd4);
      k = 0;
      while (dir_state != 2'd2 && k < 10) begin nxt(); k++; end
      nxt(); nxt();
      chk("rev_hb", 32'(hb_in[1:0]), 32'b10);
      dir_fwd = 1'b1;
      repeat (20) nxt();
      chk("both_idle", 32'(dir_state), 32'd0);

      // Over-current pulse on channel 0 while running at 100 %.
      dir_rev = 1'b0; duty_code = 3'd4;
      repeat (30) nxt();
      oc[0] = 1'b1;
      k = 0;
      while (pwm_en[0] && k < 10) begin nxt(); k++; end
      chk("oc_latency", 32'(k), 32'd3);
      oc[0] = 1'b0;
      chk("oc_fault0", 32'(fault[0]), 32'd1);
      chk("oc_ch1_ok", 32'(pwm_en[1]), 32'd1);
      k = 0;
      while (fault[0] && k < 40) begin nxt(); k++; end
      chk("oc_release", 32'(k), 32'd12);

      // Long over-current on channel 1, then enable dropped mid-lockout.
      repeat (25) nxt();
      oc[1] = 1'b1;
      repeat (30) nxt();
      chk("oc1_held", 32'(fault[1]), 32'd1);
      oc[1] = 1'b0;
      repeat (3) nxt();
      enable = 1'b0;
      k = 0;
      prev_fault1 = fault[1];
      while (dir_state != 2'd3 && k < 10) begin prev_fault1 = fault[1]; nxt(); k++; end
      chk("en_drop_prev", 32'(prev_fault1), 32'd1);
      chk("en_drop_clear", 32'(fault[1]), 32'd0);

      // Randomised operation against the model.
      for (int c = 0; c < 1500; c++) begin
         nxt();
         if ($urandom_range(39) == 0) enable = ($urandom_range(9) != 0);
         if ($urandom_range(29) == 0) begin
            dir_fwd = 1'($urandom_range(1)); dir_rev = 1'($urandom_range(1));
         end
         if ($urandom_range(24) == 0) duty_code = 3'($urandom_range(7));
         for (int b = 0; b < N_CH; b++)
            if ($urandom_range(59) == 0) oc[b] = ~oc[b];
      end

      // Reset while driving: outputs must drop with no clock edge.
      enable = 1'b1; dir_fwd = 1'b1; dir_rev = 1'b0; duty_code = 3'd4; oc = '0;
      repeat (45) nxt();
      chk("pre_rst_pwm", 32'(pwm_en), 32'b11);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_pwm", 32'(pwm_en), 32'd0);
      chk("rst_hb", 32'(hb_in), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_dir", 32'(dir_state), 32'd0);
      repeat (2) nxt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/motor_drive_ctrl.md
Name: motor_drive_ctrl

Overview:
- Parametrised successor to the rover's single-channel PWM/switch/comparator logic.
- Generates per-channel PWM enables and H-bridge input pairs from switch-level controls.
- Direction changes pass through a dead-time state machine; each channel has a latched over-current lockout with a timed retry.
- Sits between the switch inputs and comparator inputs on JA and the H-bridge, and exports status for the seven-segment display.

Parameters:
- N_CH, 2, number of motor channels (each has one enable, two H-bridge inputs, one comparator input).
- CNT_W, 10, PWM period counter width.
- PERIOD, 1000, PWM period in clk cycles; must satisfy 2 <= PERIOD <= 2**CNT_W.
- DUTY_W, 3, duty code width.
- DUTY_STEPS, 4, duty code value equal to 100%.
- DEAD_CYC, 50, dead-time cycles on direction change.
- OC_HOLD, 1000, lockout cycles after an over-current trip.
- SYNC_STAGES, 2, synchroniser depth on all asynchronous inputs.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  primary enable (switch)
- dir_fwd  in  1  forward request (switch)
- dir_rev  in  1  reverse request (switch)
- duty_code  in  DUTY_W  requested duty in steps of 1/DUTY_STEPS
- oc  in  N_CH  comparator outputs, 1 = over current limit
- pwm_en  out  N_CH  H-bridge enable per channel
- hb_in  out  2*N_CH  H-bridge inputs; bit 2i = IN_A of channel i, bit 2i+1 = IN_B of channel i
- fault  out  N_CH  1 = channel i locked out
- dir_state  out  2  0 IDLE, 1 FWD, 2 REV, 3 DEAD

Behaviour:
- Reset (rst_n low, asynchronous): pwm_en=0, hb_in=0, fault=0, dir_state=IDLE, counters=0, duty latch=0. Release is synchronous to clk.
- Input sync: enable, dir_fwd, dir_rev, duty_code and oc each pass through SYNC_STAGES flops. All timing below is measured from the synchronised value.
- Period counter: counts 0..PERIOD-1, then wraps to 0. It runs whenever the block is out of reset.
- Duty latch: at count==0, capture cmp = min(duty_code, DUTY_STEPS) * PERIOD / DUTY_STEPS.
  - Use integer division with the intermediate product at CNT_W+DUTY_W bits.
  - A duty_code change mid-period takes effect at the next period start; PWM never glitches.
- PWM raw: pwm_raw = (count < cmp). Code 0 gives constant 0; code >= DUTY_STEPS gives constant 1.
- Direction request decode: req = FWD if fwd & ~rev; REV if rev & ~fwd; otherwise IDLE (both set means IDLE).
- Direction FSM:
  - IDLE -> FWD or REV when enable=1 and req is FWD or REV.
  - FWD or REV -> DEAD when req differs from the current direction, or when enable=0.
  - DEAD holds DEAD_CYC cycles, then goes to IDLE. From IDLE, a pending req is taken on the next cycle.
  - A request that changes during DEAD does not shorten it.
  - In IDLE and DEAD: pwm_en=0 and hb_in=0 (coast).
- Outputs in FWD: hb_in pair = (A=1, B=0). In REV: (A=0, B=1).
  - pwm_en[i] = pwm_raw & ~fault[i].
  - All outputs are registered, so there is 1 cycle of latency from the FSM/counter to the pins.
- Over-current per channel:
  - Trip: synchronised oc[i]=1 while in FWD or REV sets fault[i]=1. pwm_en[i] goes 0 on the next clk edge. Worst case is SYNC_STAGES+1 cycles from a raw oc edge to pwm_en low.
  - The tripped channel's hb_in pair is held unchanged. Other channels are unaffected.
  - Hold timer loads OC_HOLD on trip. It counts down only while oc[i]=0, and reloads if oc[i] reasserts.
  - Fault clears when the timer reaches 0. The channel re-enables at the next count==0 boundary, never mid-period.
  - enable=0 clears all faults and timers immediately, in the same cycle as the FSM moves to DEAD.
  - A trip and a direction change in the same cycle: the fault is set and the FSM still enters DEAD.
- dir_state is the registered FSM state and drives the display.

Decomposition:
- Package motor_pkg holds:
  - dir_state_t enum: IDLE=0, FWD=1, REV=2, DEAD=3.
  - hb pair constants: HB_FWD=2'b01 and HB_REV=2'b10 (bit0=A), and HB_OFF=2'b00.
- One sub-module, oc_guard, instantiated N_CH times. It contains the oc synchroniser, the fault flag and the hold timer, with inputs active, period_start and clear.
- The period counter, duty latch and direction FSM stay in the top module.

Test Plan (PERIOD=20, DEAD_CYC=4, OC_HOLD=10, SYNC_STAGES=2):
- Reset mid-run: assert rst_n=0 during FWD with pwm_en high -> all outputs 0 immediately, with no clk edge required; dir_state=0.
- enable=1, fwd=1, duty_code=2 -> dir_state=FWD, hb_in[1:0]=01, pwm_en[0] high for 10 of every 20 cycles. Changing to duty_code=3 mid-period gives 15/20 only from the next period. duty_code=7 gives constant high.
- FWD, then fwd=0 and rev=1 -> DEAD for exactly 4 cycles with pwm_en=0 and hb_in=0, then IDLE, then REV with hb_in[1:0]=10. Setting both fwd and rev -> DEAD, then IDLE held.
- Raw oc[0] pulse for 3 cycles while running -> pwm_en[0]=0 within 3 cycles, fault[0]=1, channel 1 unaffected. fault clears 10 cycles after synchronised oc falls. pwm_en[0] resumes at the next count==0.
- oc[1] held high for 30 cycles -> fault[1] held throughout. The timer starts only after release. Dropping enable mid-lockout clears fault[1] the same cycle.
